// File: rtl/ctrl_if.sv
// Control bundle between the instruction decoder and the datapath.
// The controller is the master: it consumes instruction fields and drives control selects.
interface ctrl_if;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       b;
    logic [2:0] imm_type;
    logic       inst_sel;
    logic       reg_wr;
    logic [3:0] alu_op;
    logic [2:0] cmp_op;
    logic [1:0] pc_sel;
    logic       mem_sel;
    logic [1:0] rd_sel;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [2:0] sel_type;
    logic       we;

    modport master (
        input  opcode, func3, func7, b,
        output imm_type, inst_sel, reg_wr, alu_op, cmp_op, pc_sel,
               mem_sel, rd_sel, alu1_sel, alu2_sel, sel_type, we
    );

    modport slave (
        output opcode, func3, func7, b,
        input  imm_type, inst_sel, reg_wr, alu_op, cmp_op, pc_sel,
               mem_sel, rd_sel, alu1_sel, alu2_sel, sel_type, we
    );
endinterface

// File: rtl/ctrl.sv
// Multi-cycle RV32I control unit: decodes opcode/func3/func7 into datapath selects,
// stalls one cycle for load write-back and inserts one NOP after a taken jump/branch.
module ctrl (
    input  logic   clk,
    input  logic   rst,
    ctrl_if.master bus
);
    typedef enum logic [1:0] {EXEC = 2'd0, LOAD_WB = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [4:0] OP_OP = 5'b01100, OP_IMM = 5'b00100, OP_LOAD = 5'b00000,
                           OP_STORE = 5'b01000, OP_LUI = 5'b01101, OP_JAL = 5'b11011,
                           OP_JALR = 5'b11001, OP_BRANCH = 5'b11000;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                           IMM_U = 3'b011, IMM_J = 3'b100;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010,
                           ALU_XOR = 4'b0011, ALU_SRL = 4'b0100, ALU_SRA = 4'b0101,
                           ALU_OR = 4'b0110, ALU_AND = 4'b0111, ALU_SLT = 4'b1000,
                           ALU_SLTU = 4'b1001;
    localparam logic [1:0] PC_PLUS4 = 2'b00, PC_ALU = 2'b01, PC_HOLD = 2'b10;
    localparam logic [1:0] RD_ALU = 2'b00, RD_MEM = 2'b01, RD_PC4 = 2'b10, RD_IMM = 2'b11;
    localparam logic [2:0] SEL_WORD = 3'b010;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    state_t state_q, state_d;

    logic [2:0] imm_type, sel_type;
    logic       inst_sel, reg_wr, mem_sel, alu1_sel, alu2_sel, we;
    logic [3:0] alu_op;
    logic [1:0] pc_sel, rd_sel;

    // Register-register and register-immediate share one table; only 000 differs.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic [6:0] f7,
                                              input logic is_imm);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (!is_imm && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        reg_wr   = 1'b0;
        we       = 1'b0;
        inst_sel = 1'b0;
        pc_sel   = PC_PLUS4;
        mem_sel  = 1'b0;
        rd_sel   = RD_ALU;
        alu1_sel = 1'b0;
        alu2_sel = 1'b0;
        alu_op   = ALU_ADD;
        imm_type = IMM_I;
        sel_type = SEL_WORD;

        case (state_q)
            EXEC: begin
                case (bus.opcode)
                    OP_OP: begin
                        reg_wr = 1'b1;
                        alu_op = alu_decode(bus.func3, bus.func7, 1'b0);
                    end
                    OP_IMM: begin
                        reg_wr   = 1'b1;
                        alu2_sel = 1'b1;
                        alu_op   = alu_decode(bus.func3, bus.func7, 1'b1);
                    end
                    OP_LOAD: begin
                        alu2_sel = 1'b1;
                        mem_sel  = 1'b1;
                        pc_sel   = PC_HOLD;
                        sel_type = bus.func3;
                        state_d  = LOAD_WB;
                    end
                    OP_STORE: begin
                        alu2_sel = 1'b1;
                        imm_type = IMM_S;
                        mem_sel  = 1'b1;
                        we       = 1'b1;
                        sel_type = bus.func3;
                    end
                    OP_LUI: begin
                        imm_type = IMM_U;
                        rd_sel   = RD_IMM;
                        reg_wr   = 1'b1;
                    end
                    OP_JAL, OP_JALR: begin
                        alu1_sel = (bus.opcode == OP_JAL);
                        imm_type = (bus.opcode == OP_JAL) ? IMM_J : IMM_I;
                        alu2_sel = 1'b1;
                        rd_sel   = RD_PC4;
                        reg_wr   = 1'b1;
                        pc_sel   = PC_ALU;
                        state_d  = FLUSH;
                    end
                    OP_BRANCH: begin
                        imm_type = IMM_B;
                        alu1_sel = 1'b1;
                        alu2_sel = 1'b1;
                        if (bus.b) begin
                            pc_sel  = PC_ALU;
                            state_d = FLUSH;
                        end
                    end
                    default: ;
                endcase
            end
            LOAD_WB: begin
                // The held LOAD keeps its address/size decode while the data is written back.
                alu2_sel = 1'b1;
                sel_type = bus.func3;
                reg_wr   = 1'b1;
                rd_sel   = RD_MEM;
                state_d  = EXEC;
            end
            FLUSH: begin
                inst_sel = 1'b1;
                state_d  = EXEC;
            end
            default: state_d = EXEC;
        endcase

        if (rst) begin
            reg_wr   = 1'b0;
            we       = 1'b0;
            pc_sel   = PC_HOLD;
            inst_sel = 1'b1;
            mem_sel  = 1'b0;
            state_d  = EXEC;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= EXEC;
        else     state_q <= state_d;
    end

    assign bus.imm_type = imm_type;
    assign bus.inst_sel = inst_sel;
    assign bus.reg_wr   = reg_wr;
    assign bus.alu_op   = alu_op;
    assign bus.cmp_op   = bus.func3;
    assign bus.pc_sel   = pc_sel;
    assign bus.mem_sel  = mem_sel;
    assign bus.rd_sel   = rd_sel;
    assign bus.alu1_sel = alu1_sel;
    assign bus.alu2_sel = alu2_sel;
    assign bus.sel_type = sel_type;
    assign bus.we       = we;
endmodule

// File: tb/tb_ctrl.sv
// Directed bench for ctrl: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_ctrl;
    logic clk = 1'b0;
    logic rst;
    ctrl_if bus ();

    ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    localparam logic [4:0] OP = 5'b01100, OPI = 5'b00100, LOAD = 5'b00000, STORE = 5'b01000,
                           LUI = 5'b01101, JAL = 5'b11011, JALR = 5'b11001, BRANCH = 5'b11000,
                           UNK = 5'b00101;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait through one rising edge, then apply new inputs and let them settle.
    task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic br);
        @(negedge clk);
        bus.opcode = op;
        bus.func3  = f3;
        bus.func7  = f7;
        bus.b      = br;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(OP, 3'b000, 7'b0000000, 1'b0);
        check("rst_reg_wr",   bus.reg_wr,   0);
        check("rst_we",       bus.we,       0);
        check("rst_pc_sel",   bus.pc_sel,   2'b10);
        check("rst_inst_sel", bus.inst_sel, 1);
        check("rst_mem_sel",  bus.mem_sel,  0);
        drive(OP, 3'b000, 7'b0000000, 1'b0);
        rst = 1'b0;
        #1;

        // Register-register ALU decode
        drive(OP, 3'b000, 7'b0100000, 1'b0);
        check("op_sub_alu", bus.alu_op, 4'b0001);
        check("op_sub_wr",  bus.reg_wr, 1);
        check("op_sub_inst", bus.inst_sel, 0);
        drive(OP, 3'b000, 7'b0000000, 1'b0);
        check("op_add_alu", bus.alu_op, 4'b0000);
        drive(OP, 3'b010, 7'b0000000, 1'b0);
        check("op_slt_alu", bus.alu_op, 4'b1000);
        drive(OP, 3'b101, 7'b0100000, 1'b0);
        check("op_sra_alu", bus.alu_op, 4'b0101);
        drive(OP, 3'b101, 7'b0000000, 1'b0);
        check("op_srl_alu", bus.alu_op, 4'b0100);
        drive(OP, 3'b111, 7'b0000000, 1'b0);
        check("op_and_alu", bus.alu_op, 4'b0111);

        // Immediate form ignores func7 for 000
        drive(OPI, 3'b000, 7'b0100000, 1'b0);
        check("opi_add_alu", bus.alu_op,   4'b0000);
        check("opi_alu2",    bus.alu2_sel, 1);
        check("opi_wr",      bus.reg_wr,   1);

        // Load: address cycle then write-back cycle
        drive(LOAD, 3'b100, 7'b0000000, 1'b0);
        check("ld1_mem_sel",  bus.mem_sel,  1);
        check("ld1_pc_sel",   bus.pc_sel,   2'b10);
        check("ld1_reg_wr",   bus.reg_wr,   0);
        check("ld1_sel_type", bus.sel_type, 3'b100);
        check("ld1_alu2",     bus.alu2_sel, 1);
        drive(LOAD, 3'b100, 7'b0000000, 1'b0);
        check("ld2_reg_wr",   bus.reg_wr,   1);
        check("ld2_rd_sel",   bus.rd_sel,   2'b01);
        check("ld2_pc_sel",   bus.pc_sel,   2'b00);
        check("ld2_mem_sel",  bus.mem_sel,  0);
        check("ld2_sel_type", bus.sel_type, 3'b100);
        drive(UNK, 3'b000, 7'b0000000, 1'b0);
        check("nop_reg_wr",   bus.reg_wr,   0);
        check("nop_pc_sel",   bus.pc_sel,   2'b00);
        check("nop_inst_sel", bus.inst_sel, 0);

        // Store
        drive(STORE, 3'b001, 7'b0000000, 1'b0);
        check("st_we",       bus.we,       1);
        check("st_imm_type", bus.imm_type, 3'b001);
        check("st_sel_type", bus.sel_type, 3'b001);
        check("st_reg_wr",   bus.reg_wr,   0);

        // Branch taken then not taken
        drive(BRANCH, 3'b101, 7'b0000000, 1'b1);
        check("br_t_cmp_op", bus.cmp_op,   3'b101);
        check("br_t_pc_sel", bus.pc_sel,   2'b01);
        check("br_t_imm",    bus.imm_type, 3'b010);
        drive(BRANCH, 3'b101, 7'b0000000, 1'b1);
        check("br_flush_inst", bus.inst_sel, 1);
        check("br_flush_pc",   bus.pc_sel,   2'b00);
        drive(BRANCH, 3'b101, 7'b0000000, 1'b0);
        check("br_nt_pc_sel", bus.pc_sel,   2'b00);
        check("br_nt_inst",   bus.inst_sel, 0);
        drive(OP, 3'b000, 7'b0000000, 1'b0);
        check("br_nt_noflush", bus.inst_sel, 0);

        // JAL then JALR
        drive(JAL, 3'b000, 7'b0000000, 1'b0);
        check("jal_reg_wr",   bus.reg_wr,   1);
        check("jal_rd_sel",   bus.rd_sel,   2'b10);
        check("jal_alu1",     bus.alu1_sel, 1);
        check("jal_imm_type", bus.imm_type, 3'b100);
        check("jal_pc_sel",   bus.pc_sel,   2'b01);
        drive(OP, 3'b000, 7'b0000000, 1'b0);
        check("jal_flush_inst", bus.inst_sel, 1);
        check("jal_flush_wr",   bus.reg_wr,   0);
        drive(JALR, 3'b000, 7'b0000000, 1'b0);
        check("jalr_alu1",   bus.alu1_sel, 0);
        check("jalr_imm",    bus.imm_type, 3'b000);
        check("jalr_pc_sel", bus.pc_sel,   2'b01);
        drive(LUI, 3'bxxx, 7'bxxxxxxx, 1'b0);
        check("jalr_flush_inst", bus.inst_sel, 1);

        // LUI with unknown func fields
        drive(LUI, 3'bxxx, 7'bxxxxxxx, 1'b0);
        check("lui_rd_sel", bus.rd_sel,   2'b11);
        check("lui_imm",    bus.imm_type, 3'b011);
        check("lui_alu_op", bus.alu_op,   4'b0000);
        check("lui_reg_wr", bus.reg_wr,   1);

        // Reset during load write-back
        drive(LOAD, 3'b010, 7'b0000000, 1'b0);
        drive(LOAD, 3'b010, 7'b0000000, 1'b0);
        check("rwb_pre_wr", bus.reg_wr, 1);
        rst = 1'b1;
        #1;
        check("rwb_reg_wr",  bus.reg_wr,  0);
        check("rwb_pc_sel",  bus.pc_sel,  2'b10);
        drive(OP, 3'b000, 7'b0000000, 1'b0);
        rst = 1'b0;
        #1;
        check("rwb_exec_rd_sel", bus.rd_sel,   2'b00);
        check("rwb_exec_inst",   bus.inst_sel, 0);
        check("rwb_exec_wr",     bus.reg_wr,   1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ctrl.md
CTRL -- requirements
Module: ctrl

Interface
REQ-001 The interface SHALL include `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The interface SHALL include `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 The interface SHALL include `opcode`, input, 5 bits: instr[6:2]. Encodings: OP=01100, OP_IMM=00100, LOAD=00000, STORE=01000, LUI=01101, JAL=11011, JALR=11001, BRANCH=11000.
REQ-004 The interface SHALL include `func3`, input, 3 bits: instr[14:12].
REQ-005 The interface SHALL include `func7`, input, 7 bits: instr[31:25].
REQ-006 The interface SHALL include `b`, input, 1 bit: branch-condition result from the comparator; 1 = taken.
REQ-007 The interface SHALL include `imm_type`, output, 3 bits: I=000, S=001, B=010, U=011, J=100.
REQ-008 The interface SHALL include `inst_sel`, output, 1 bit: INST_MEM=0, INST_NOP=1 (substitute a NOP).
REQ-009 The interface SHALL include `reg_wr`, output, 1 bit: register-file write enable.
REQ-010 The interface SHALL include `alu_op`, output, 4 bits: ADD=0000, SUB=0001, SLL=0010, XOR=0011, SRL=0100, SRA=0101, OR=0110, AND=0111, SLT=1000, SLTU=1001.
REQ-011 The interface SHALL include `cmp_op`, output, 3 bits: equals `func3`. Codes: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
REQ-012 The interface SHALL include `pc_sel`, output, 2 bits: PC_PLUS4=00, PC_ALU=01 (ALU result as next PC), PC_HOLD=10.
REQ-013 The interface SHALL include `mem_sel`, output, 1 bit: memory address source; MEM_PC=0, MEM_ALU=1.
REQ-014 The interface SHALL include `rd_sel`, output, 2 bits: RD_ALU=00, RD_MEM=01, RD_PC4=10, RD_IMM=11.
REQ-015 The interface SHALL include `alu1_sel`, output, 1 bit: RS1=0, PC=1.
REQ-016 The interface SHALL include `alu2_sel`, output, 1 bit: RS2=0, IMM=1.
REQ-017 The interface SHALL include `sel_type`, output, 3 bits: load/store size and sign; equals `func3` for LOAD and STORE, otherwise WORD=010.
REQ-018 The interface SHALL include `we`, output, 1 bit: data-memory write enable.

Function
REQ-019 All outputs SHALL be combinational from the state register and the inputs; the only storage SHALL be a 2-bit state register with states EXEC, LOAD_WB and FLUSH.
REQ-020 Default outputs in EXEC SHALL be: reg_wr=0, we=0, inst_sel=INST_MEM, pc_sel=PC_PLUS4, mem_sel=MEM_PC, rd_sel=RD_ALU, alu1_sel=RS1, alu2_sel=RS2, alu_op=ADD, imm_type=I.
REQ-021 For OP, decode SHALL be: reg_wr=1; alu_op from func3: 000 gives SUB if func7=0100000 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 gives SRA if func7=0100000 else SRL; 110 OR; 111 AND.
REQ-022 For OP_IMM, decode SHALL be as for OP, except alu2_sel=IMM, imm_type=I, and func3=000 always gives ADD (func7 ignored).
REQ-023 For LOAD, decode SHALL be: alu2_sel=IMM, imm_type=I, alu_op=ADD, mem_sel=MEM_ALU, pc_sel=PC_HOLD, reg_wr=0; next state LOAD_WB.
REQ-024 For STORE, decode SHALL be: alu2_sel=IMM, imm_type=S, alu_op=ADD, mem_sel=MEM_ALU, we=1, reg_wr=0.
REQ-025 For LUI, decode SHALL be: imm_type=U, rd_sel=RD_IMM, reg_wr=1.
REQ-026 For JAL, decode SHALL be: alu1_sel=PC, alu2_sel=IMM, imm_type=J, alu_op=ADD, rd_sel=RD_PC4, reg_wr=1, pc_sel=PC_ALU; next state FLUSH.
REQ-027 For JALR, decode SHALL be as for JAL, but with alu1_sel=RS1 and imm_type=I.
REQ-028 For BRANCH, decode SHALL be: imm_type=B, alu1_sel=PC, alu2_sel=IMM, alu_op=ADD, reg_wr=0. If b=1: pc_sel=PC_ALU and next state FLUSH. If b=0: pc_sel=PC_PLUS4 and state stays EXEC.
REQ-029 In LOAD_WB, the combinational ALU/immediate/mux decode of the held LOAD SHALL be kept, with reg_wr=1, rd_sel=RD_MEM, mem_sel=MEM_PC, pc_sel=PC_PLUS4, we=0; next state EXEC unconditionally.
REQ-030 In FLUSH, outputs SHALL be: inst_sel=INST_NOP, reg_wr=0, we=0, pc_sel=PC_PLUS4, everything else at its default; next state EXEC.
REQ-031 Any unlisted opcode SHALL be treated as a NOP: defaults only, no writes, stay in EXEC.
REQ-032 An X or unknown func3/func7 SHALL NOT affect outputs for opcodes that ignore those fields.

Reset
REQ-033 While rst=1 at a rising clk edge, the state SHALL become EXEC.
REQ-034 While rst is high, the outputs SHALL be forced combinationally to: reg_wr=0, we=0, pc_sel=PC_HOLD, inst_sel=INST_NOP, mem_sel=MEM_PC.
REQ-035 Reset asserted in LOAD_WB or FLUSH SHALL abort that state with no write.

Verification
REQ-036 The bench SHALL check: opcode=OP, func3=000, func7=0100000 -> alu_op=0001, reg_wr=1; then func7=0000000 -> alu_op=0000.
REQ-037 The bench SHALL check: opcode=OP, func3=010 -> alu_op=1000; func3=101 with func7=0100000 -> alu_op=0101, and with 0000000 -> 0100.
REQ-038 The bench SHALL check: opcode=LOAD, func3=100 -> cycle 1: mem_sel=1, pc_sel=10, reg_wr=0, sel_type=100; cycle 2: reg_wr=1, rd_sel=01, pc_sel=00.
REQ-039 The bench SHALL check: opcode=BRANCH, func3=101, b=1 -> cmp_op=101, pc_sel=01; next cycle inst_sel=1. With b=0 -> pc_sel=00 and no flush.
REQ-040 The bench SHALL check: opcode=JAL -> reg_wr=1, rd_sel=10, alu1_sel=1, imm_type=100, pc_sel=01, then FLUSH.
REQ-041 The bench SHALL check: rst=1 during LOAD_WB -> reg_wr=0 immediately; after release, state EXEC.
